// File: rtl/reducao_media.sv
// Block-mean downscaler: reads a LARGURA x ALTURA image from ROM and writes the
// FATOR x FATOR truncated-mean image into frame RAM, one address per cycle.
// Latency 2 edges per read; first write after FATOR^2+2 edges; no backpressure.
module reducao_media #(
  parameter int LARGURA      = 160,
  parameter int ALTURA       = 120,
  parameter int FATOR        = 2,
  parameter int LARGURA_ADDR = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic [LARGURA_ADDR-1:0] rom_addr,
  input  logic [7:0]              rom_data,
  output logic [LARGURA_ADDR-1:0] ram_wraddr,
  output logic [7:0]              ram_data,
  output logic                    ram_wren,
  output logic                    done
);

  localparam int NEW_LARG = LARGURA / FATOR;
  localparam int NEW_ALT  = ALTURA / FATOR;
  localparam int SHIFT    = 2 * $clog2(FATOR);
  localparam int ACC_W    = 8 + SHIFT;
  localparam int AW       = LARGURA_ADDR;
  localparam int DW       = (FATOR > 1)    ? $clog2(FATOR)    : 1;
  localparam int XW       = (NEW_LARG > 1) ? $clog2(NEW_LARG) : 1;
  localparam int YW       = (NEW_ALT > 1)  ? $clog2(NEW_ALT)  : 1;

  localparam logic [DW-1:0] D_MAX = DW'(FATOR - 1);
  localparam logic [XW-1:0] X_MAX = XW'(NEW_LARG - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(NEW_ALT - 1);

  typedef enum logic [1:0] {LEITURA, ESVAZIA, FIM} t_estado;

  t_estado r_estado;
  t_estado w_prox_estado;

  // traversal counters: oy, ox select the block, di, dj the pixel inside it
  logic [YW-1:0] r_oy;
  logic [XW-1:0] r_ox;
  logic [DW-1:0] r_di;
  logic [DW-1:0] r_dj;

  // two-stage tag pipeline matching the ROM read latency
  logic          r_v1, r_first1, r_last1;
  logic [AW-1:0] r_wa1;
  logic          r_v2, r_first2, r_last2;
  logic [AW-1:0] r_wa2;

  logic [ACC_W-1:0]  r_acc;
  logic [AW-1:0]     r_rom_addr;
  logic [AW-1:0]     r_ram_wraddr;
  logic [7:0]        r_ram_data;
  logic              r_ram_wren;

  logic              w_issue;
  logic              w_done;
  logic              w_restart;
  logic              w_first;
  logic              w_last;
  logic              w_ultimo;
  logic [AW-1:0]     w_addr;
  logic [AW-1:0]     w_wraddr;
  logic [ACC_W-1:0]  w_soma;

  // block tags and final-issue detection from the current counter values
  always_comb begin
    w_first  = (r_di == '0) && (r_dj == '0);
    w_last   = (r_di == D_MAX) && (r_dj == D_MAX);
    w_ultimo = w_issue && w_last && (r_ox == X_MAX) && (r_oy == Y_MAX);
  end

  // source and destination addresses; arithmetic wraps naturally at AW bits
  always_comb begin
    w_addr   = (AW'(r_oy) * AW'(FATOR) + AW'(r_di)) * AW'(LARGURA)
             + AW'(r_ox) * AW'(FATOR) + AW'(r_dj);
    w_wraddr = AW'(r_oy) * AW'(NEW_LARG) + AW'(r_ox);
    w_soma   = r_acc + ACC_W'(rom_data);
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_estado <= LEITURA;
    else       r_estado <= w_prox_estado;
  end

  // FSM next state: drain waits until both tag stages are empty, so the
  // final write has already left before done rises
  always_comb begin
    w_prox_estado = r_estado;
    case (r_estado)
      LEITURA: if (w_ultimo)          w_prox_estado = ESVAZIA;
      ESVAZIA: if (!r_v1 && !r_v2)    w_prox_estado = FIM;
      FIM:     if (start)             w_prox_estado = LEITURA;
      default:                        w_prox_estado = LEITURA;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_issue   = (r_estado == LEITURA);
    w_done    = (r_estado == FIM);
    w_restart = (r_estado == FIM) && start;
  end

  // counter advance (dj innermost) and issued address register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_oy       <= '0;
      r_ox       <= '0;
      r_di       <= '0;
      r_dj       <= '0;
      r_rom_addr <= '0;
    end else if (w_restart) begin
      r_oy <= '0;
      r_ox <= '0;
      r_di <= '0;
      r_dj <= '0;
    end else if (w_issue) begin
      r_rom_addr <= w_addr;
      if (r_dj != D_MAX) begin
        r_dj <= r_dj + 1'b1;
      end else begin
        r_dj <= '0;
        if (r_di != D_MAX) begin
          r_di <= r_di + 1'b1;
        end else begin
          r_di <= '0;
          if (r_ox != X_MAX) begin
            r_ox <= r_ox + 1'b1;
          end else begin
            r_ox <= '0;
            r_oy <= (r_oy == Y_MAX) ? '0 : r_oy + 1'b1;
          end
        end
      end
    end
  end

  // tag pipeline: stage 1 follows the address, stage 2 lines up with rom_data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1     <= 1'b0;
      r_first1 <= 1'b0;
      r_last1  <= 1'b0;
      r_wa1    <= '0;
      r_v2     <= 1'b0;
      r_first2 <= 1'b0;
      r_last2  <= 1'b0;
      r_wa2    <= '0;
    end else begin
      r_v1     <= w_issue;
      r_first1 <= w_first;
      r_last1  <= w_last;
      r_wa1    <= w_wraddr;
      r_v2     <= r_v1;
      r_first2 <= r_first1;
      r_last2  <= r_last1;
      r_wa2    <= r_wa1;
    end
  end

  // accumulate samples and emit the truncated mean on the last one of a block
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc        <= '0;
      r_ram_wraddr <= '0;
      r_ram_data   <= '0;
      r_ram_wren   <= 1'b0;
    end else begin
      r_ram_wren <= r_v2 && r_last2;
      if (r_v2) begin
        r_acc <= r_first2 ? ACC_W'(rom_data) : w_soma;
        if (r_last2) begin
          r_ram_data   <= w_soma[SHIFT +: 8];
          r_ram_wraddr <= r_wa2;
        end
      end
    end
  end

  assign rom_addr   = r_rom_addr;
  assign ram_wraddr = r_ram_wraddr;
  assign ram_data   = r_ram_data;
  assign ram_wren   = r_ram_wren;
  assign done       = w_done;

endmodule

// File: doc/reducao_media.md
# reducao_media

Downscaler that reads a LARGURA×ALTURA 8-bit grayscale image from the source ROM and writes a (LARGURA/FATOR)×(ALTURA/FATOR) image into the frame RAM. Each output pixel is the truncated mean of a FATOR×FATOR source block. It is the zoom-out counterpart of the nearest-neighbour zoom-in path. It uses the same ROM-read / RAM-write port set, so the display mux can select either path.

## Interface
- LARGURA, 160: source width in pixels; must be a multiple of FATOR.
- ALTURA, 120: source height in pixels; must be a multiple of FATOR.
- FATOR, 2: reduction factor; legal values are 2, 4, 8.
- LARGURA_ADDR, 15: width of the ROM and RAM address buses.
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  restart request; sampled only while done=1.
- rom_addr  out  LARGURA_ADDR  registered source read address.
- rom_data  in  8  source pixel from a synchronous ROM that registers its address.
- ram_wraddr  out  LARGURA_ADDR  registered destination address.
- ram_data  out  8  registered destination pixel.
- ram_wren  out  1  one-cycle write strobe per output pixel.
- done  out  1  high once the whole frame is written; held until start or reset.

## Operation
- Derived values:
  - NEW_LARG = LARGURA/FATOR; NEW_ALT = ALTURA/FATOR.
  - SHIFT = 2·log2(FATOR).
  - The accumulator is 8+SHIFT bits wide, so it never overflows.
- Traversal order is block-major:
  - Output row oy runs 0..NEW_ALT-1; output column ox runs 0..NEW_LARG-1.
  - Within a block, di runs 0..FATOR-1 and dj runs 0..FATOR-1, with dj innermost.
- Issue address = (oy·FATOR+di)·LARGURA + ox·FATOR + dj, truncated to LARGURA_ADDR. One address is issued per cycle with no bubbles.
- A 2-stage valid/tag pipeline carries "first-of-block" and "last-of-block" flags alongside each issued address.
- Capture behaviour, when the tagged sample arrives:
  - First-of-block: acc <= rom_data.
  - Any other sample: acc <= acc + rom_data.
  - Last-of-block, in the same edge:
    - ram_data <= (acc + rom_data) >> SHIFT, truncating.
    - ram_wraddr <= oy·NEW_LARG + ox for that block.
    - ram_wren <= 1.
  - ram_wren is 0 on every other cycle.
- States:
  - LEITURA: issuing addresses. After the final issue (oy=NEW_ALT-1, ox=NEW_LARG-1, di=dj=FATOR-1) → ESVAZIA.
  - ESVAZIA: no issue; rom_addr holds its last value. When the final sample is captured → FIM.
  - FIM: done=1 and ram_wren=0. If start=1 → LEITURA with all counters at 0 and done cleared.
- start is ignored in LEITURA and ESVAZIA.
- reset, asserted at any time (including mid-frame):
  - All outputs go to 0 immediately; state goes to LEITURA with counters at 0.
  - Valid pipeline and accumulator are cleared; no partial write is emitted.
  - The frame restarts from address 0 after reset is released.

## Timing
- Reset values: rom_addr=0, ram_wraddr=0, ram_data=0, ram_wren=0, done=0.
- Read latency: 2 edges.
  - The address registered at edge k is latched by the ROM at k+1.
  - Its data is captured by this block at k+2.
- Let E1 be the first edge after reset is released.
- Issue timing:
  - Issue i (0-based) is registered at E(1+i).
  - The last issue is at E(N), where N = LARGURA·ALTURA.
- Output timing:
  - The first ram_wren pulse is high after E(FATOR²+2).
  - Later pulses follow every FATOR² cycles.
  - The last pulse is high after E(N+2).
- done rises after E(N+3), while ram_wren falls to 0 at that same edge. Total frame time is N+3 cycles.
- Restart: start=1 sampled at edge S in FIM.
  - done=0 after S.
  - The first new issue is registered at S+1.
  - Timing then repeats relative to S.
- ram_wraddr and ram_data are only meaningful while ram_wren=1; between pulses they hold their last values.

## Test plan
- Default parameters, ROM filled with 0x80 → exactly 4800 ram_wren pulses:
  - All pulses write 0x80.
  - Addresses 0..4799 appear each exactly once, in order.
  - done=1 after E(19203).
- LARGURA=8, ALTURA=4, FATOR=2, ROM[k]=k:
  - Block (0,0) reads 0,1,8,9 and writes 4 at address 0.
  - Block (ox=3, oy=1) reads 22,23,30,31 and writes 26 at address 7.
  - The first pulse is high after E6.
- FATOR=4, ROM all 0xFF → every output is 0xFF; no wrap in the 12-bit accumulator.
- Truncation check, FATOR=2: block {1,2,3,3} (sum 9) writes 2; block {0,0,0,3} writes 0.
- Reset asserted in the middle of block 100 for 3 cycles:
  - While reset is asserted, all outputs are 0.
  - After release, the first write is again address 0 with the correct mean.
  - No write ever occurs to address 100 with a partial sum.
- start handling:
  - Hold start=1 during the whole frame → no effect before done.
  - Once done=1, a start pulse clears done at the next edge; the frame repeats with identical write sequence and timing.
